staged_reg_file: RTL and testbench
==================================

STAGED_REG_FILE -- requirements
Module: staged_reg_file

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 3, number of read ports, legal range 1..8.
- BYPASS, 1, 1 = reads return the staged value of dirty entries; 0 = reads return committed values only.
- ZERO_R0, 1, 1 = entry 0 hardwired to zero.

REQ-002 Ports SHALL be, one per line:
- clk, in, 1, rising-edge clock.
- Rst, in, 1, reset.
- wr_en, in, 1, stage a write this cycle.
- wr_addr, in, ADDR_W, staged write address.
- wr_data, in, DATA_W, staged write data.
- step, in, 1, commit strobe; promotes all staged entries.
- flush, in, 1, discard all staged entries.
- rd_addr, in, NUM_RD*ADDR_W, packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data, out, NUM_RD*DATA_W, packed read data, same packing as rd_addr.
- dirty_cnt, out, ADDR_W+1, number of staged (dirty) entries.
- commit_done, out, 1, one-cycle pulse after a commit.

REQ-003 Reset Rst SHALL be synchronous, active-high.

Function
REQ-004 Storage SHALL consist of a committed array C, a staging array S and a dirty bitmask D, each with 2**ADDR_W entries.

REQ-005 wr_en=1 SHALL write wr_data into S[wr_addr] and set D[wr_addr] at the next rising edge; C SHALL be unchanged.

REQ-006 A repeated write to a dirty entry SHALL overwrite S and leave dirty_cnt unchanged.

REQ-007 step=1 with flush=0 SHALL copy S[i] into C[i] for every i with D[i]=1 in that same edge, clear all D bits, and drive commit_done=1 in the following cycle only.

REQ-008 flush=1 SHALL clear all D bits, leave C unchanged, and leave commit_done=0, regardless of step.

REQ-009 When wr_en and step are both active in the same cycle, the commit SHALL use S and D as they stood before the edge. The new write SHALL then be staged: D[wr_addr]=1 afterwards, and dirty_cnt=1 afterwards.

REQ-010 When wr_en and flush are both active in the same cycle, old staged entries SHALL be discarded and the new write SHALL survive as staged, giving dirty_cnt=1.

REQ-011 Reads SHALL be combinational with zero latency.
- rd_data[k] = S[a] if BYPASS=1 and D[a]=1; otherwise C[a]; where a = address of port k.
- Write-to-read visibility SHALL take effect from the cycle after the write edge; there SHALL be no same-cycle wr_data forwarding.

REQ-012 With ZERO_R0=1:
- writes to address 0 SHALL be ignored: S, D and dirty_cnt unaffected;
- reads of address 0 SHALL return 0 on every port.

REQ-013 dirty_cnt SHALL equal popcount(D) and SHALL be registered, updating in the same edge as D; its maximum value is 2**ADDR_W.

REQ-014 commit_done SHALL pulse even when D was empty at step.

REQ-015 All read ports SHALL be independent; identical addresses on several ports SHALL return identical data.

REQ-016 step or flush held high for several cycles SHALL act once per cycle; commit_done SHALL remain high for each cycle following a cycle with step=1 and flush=0.

Reset
REQ-017 On Rst=1 at a rising edge:
- C[i] and S[i] SHALL be loaded with i zero-extended or truncated to DATA_W;
- when ZERO_R0=1, C[0] and S[0] SHALL be 0;
- D SHALL be cleared, dirty_cnt SHALL be 0 and commit_done SHALL be 0.

REQ-018 Rst SHALL take priority over wr_en, step and flush in the same cycle; any staged data SHALL be lost.

REQ-019 Reset asserted between a step edge and the commit_done pulse SHALL suppress that pulse.

Verification
REQ-020 Reset value check: Rst for 1 cycle, then read addresses 0, 1, 31 on ports 0..2 -> rd_data = 0x0, 0x1, 0x1F; dirty_cnt=0.

REQ-021 Staging and bypass check, BYPASS=1: write 0xDEADBEEF to address 5 -> next cycle reads at 5 return 0xDEADBEEF and dirty_cnt=1. Repeat with BYPASS=0 -> reads at 5 return 0x5 until step, then 0xDEADBEEF with commit_done=1 for one cycle.

REQ-022 Flush check: stage writes to addresses 3 and 7, then flush -> reads return 0x3 and 0x7, and dirty_cnt=0; commit_done remains 0.

REQ-023 Simultaneous events:
- stage 0xA at address 2; next cycle step with wr_en writing 0xB to address 2 -> C[2]=0xA, S[2]=0xB, dirty_cnt=1;
- step and flush together -> C unchanged, no commit_done.

REQ-024 Zero register check: write 0x1234 to address 0, then step -> all ports read 0x0 at address 0, and dirty_cnt stays 0.

REQ-025 Reset mid-operation: stage 3 entries, assert Rst in the same cycle as step -> C holds reset values, dirty_cnt=0, commit_done stays 0.

Source files
------------

// File: rtl/staged_reg_file.sv
// Register file with a staging layer: writes land in a shadow array and only
// become architectural when a step strobe promotes every dirty entry at once.
module staged_reg_file #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_RD  = 3,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       step,
  input  logic                       flush,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [ADDR_W:0]            dirty_cnt,
  output logic                       commit_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0][DATA_W-1:0] cMem;
  logic [DEPTH-1:0][DATA_W-1:0] sMem;
  logic [DEPTH-1:0]             dirty;
  logic [DEPTH-1:0]             dirtyNext_c;
  logic [CNT_W-1:0]             cntNext_c;
  logic                         wrAccept_c;
  logic                         commit_c;

  function automatic logic [DATA_W-1:0] resetVal(input int unsigned idx);
    return (ZERO_R0 != 0 && idx == 0) ? '0 : DATA_W'(idx);
  endfunction

  assign wrAccept_c = wr_en && !(ZERO_R0 != 0 && wr_addr == '0);
  assign commit_c   = step && !flush;

  // Step and flush both empty the dirty set; a same-cycle write is staged on top.
  always_comb begin
    dirtyNext_c = (step || flush) ? '0 : dirty;
    if (wrAccept_c) begin
      dirtyNext_c[wr_addr] = 1'b1;
    end
  end

  always_comb begin
    cntNext_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cntNext_c = cntNext_c + CNT_W'(dirtyNext_c[ADDR_W'(i)]);
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cMem[ADDR_W'(i)] <= resetVal(i);
        sMem[ADDR_W'(i)] <= resetVal(i);
      end
      dirty       <= '0;
      dirty_cnt   <= '0;
      commit_done <= 1'b0;
    end else begin
      // Commit reads S and D as they stood before this edge.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (commit_c && dirty[ADDR_W'(i)]) begin
          cMem[ADDR_W'(i)] <= sMem[ADDR_W'(i)];
        end
      end
      if (wrAccept_c) begin
        sMem[wr_addr] <= wr_data;
      end
      dirty       <= dirtyNext_c;
      dirty_cnt   <= cntNext_c;
      commit_done <= commit_c;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRead
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign word = (BYPASS != 0 && dirty[addr]) ? sMem[addr] : cMem[addr];
    assign rd_data[k*DATA_W +: DATA_W] = (ZERO_R0 != 0 && addr == '0) ? '0 : word;
  end

endmodule

// File: tb/tb_staged_reg_file.sv
// Directed bench for staged_reg_file: a bypassing and a non-bypassing instance
// share one stimulus stream and are checked against hand-computed tables.
module tb_staged_reg_file;

  logic        clk = 1'b0;
  logic        Rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        step;
  logic        flush;
  logic [14:0] rd_addr;
  logic [95:0] rdB;
  logic [95:0] rdN;
  logic [5:0]  cntB;
  logic [5:0]  cntN;
  logic        doneB;
  logic        doneN;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  staged_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .BYPASS(1), .ZERO_R0(1)) dut (
    .clk(clk), .Rst(Rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .step(step), .flush(flush), .rd_addr(rd_addr), .rd_data(rdB),
    .dirty_cnt(cntB), .commit_done(doneB)
  );

  staged_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .BYPASS(0), .ZERO_R0(1)) dutNb (
    .clk(clk), .Rst(Rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .step(step), .flush(flush), .rd_addr(rd_addr), .rd_data(rdN),
    .dirty_cnt(cntN), .commit_done(doneN)
  );

  typedef struct {
    logic        rst, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        stp, fl;
    logic [4:0]  ra0, ra1, ra2;
    logic [31:0] b0, b1, b2;
    logic [31:0] n0, n1, n2;
    logic [31:0] cnt;
    logic        done;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic stp, input logic fl,
    input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2,
    input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
    input logic [31:0] n0, input logic [31:0] n1, input logic [31:0] n2,
    input logic [31:0] cnt, input logic done);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.stp = stp; v.fl = fl;
    v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.n0 = n0; v.n1 = n1; v.n2 = n2;
    v.cnt = cnt; v.done = done;
    return v;
  endfunction

  function automatic logic [31:0] port(input logic [95:0] bus, input int k);
    return bus[k*32 +: 32];
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic stp, input logic fl,
                       input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2);
    Rst = rst; wr_en = we; wr_addr = wa; wr_data = wd; step = stp; flush = fl;
    rd_addr = {ra2, ra1, ra0};
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    //         rst we wa     wd            stp fl  ra0    ra1    ra2    bypass expect            no-bypass expect       cnt done
    vq.push_back(mk(1, 0, 5'd0,  32'h0,        0, 0, 5'd0,  5'd1,  5'd31, 32'h0,  32'h1,  32'h1F, 32'h0, 32'h1, 32'h1F, 0, 0));
    vq.push_back(mk(0, 1, 5'd5,  DB,           0, 0, 5'd5,  5'd5,  5'd5,  DB,     DB,     DB,     32'h5, 32'h5, 32'h5,  1, 0));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        0, 0, 5'd5,  5'd0,  5'd1,  DB,     32'h0,  32'h1,  32'h5, 32'h0, 32'h1,  1, 0));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        1, 0, 5'd5,  5'd5,  5'd5,  DB,     DB,     DB,     DB,    DB,    DB,     0, 1));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        0, 0, 5'd5,  5'd5,  5'd5,  DB,     DB,     DB,     DB,    DB,    DB,     0, 0));
    vq.push_back(mk(0, 1, 5'd3,  32'h33,       0, 0, 5'd3,  5'd7,  5'd5,  32'h33, 32'h7,  DB,     32'h3, 32'h7, DB,     1, 0));
    vq.push_back(mk(0, 1, 5'd7,  32'h77,       0, 0, 5'd3,  5'd7,  5'd5,  32'h33, 32'h77, DB,     32'h3, 32'h7, DB,     2, 0));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        0, 1, 5'd3,  5'd7,  5'd5,  32'h3,  32'h7,  DB,     32'h3, 32'h7, DB,     0, 0));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        0, 0, 5'd3,  5'd7,  5'd5,  32'h3,  32'h7,  DB,     32'h3, 32'h7, DB,     0, 0));
    vq.push_back(mk(0, 1, 5'd2,  32'hA,        0, 0, 5'd2,  5'd2,  5'd2,  32'hA,  32'hA,  32'hA,  32'h2, 32'h2, 32'h2,  1, 0));
    vq.push_back(mk(0, 1, 5'd2,  32'hB,        1, 0, 5'd2,  5'd2,  5'd2,  32'hB,  32'hB,  32'hB,  32'hA, 32'hA, 32'hA,  1, 1));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        0, 0, 5'd2,  5'd2,  5'd2,  32'hB,  32'hB,  32'hB,  32'hA, 32'hA, 32'hA,  1, 0));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        1, 1, 5'd2,  5'd2,  5'd2,  32'hA,  32'hA,  32'hA,  32'hA, 32'hA, 32'hA,  0, 0));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        1, 0, 5'd2,  5'd2,  5'd2,  32'hA,  32'hA,  32'hA,  32'hA, 32'hA, 32'hA,  0, 1));
    vq.push_back(mk(0, 1, 5'd6,  32'h66,       0, 0, 5'd6,  5'd4,  5'd2,  32'h66, 32'h4,  32'hA,  32'h6, 32'h4, 32'hA,  1, 0));
    vq.push_back(mk(0, 1, 5'd4,  32'h44,       0, 1, 5'd6,  5'd4,  5'd2,  32'h6,  32'h44, 32'hA,  32'h6, 32'h4, 32'hA,  1, 0));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        1, 0, 5'd6,  5'd4,  5'd2,  32'h6,  32'h44, 32'hA,  32'h6, 32'h44, 32'hA, 0, 1));
    vq.push_back(mk(0, 1, 5'd9,  32'h90,       0, 0, 5'd9,  5'd9,  5'd9,  32'h90, 32'h90, 32'h90, 32'h9, 32'h9, 32'h9,  1, 0));
    vq.push_back(mk(0, 1, 5'd9,  32'h91,       0, 0, 5'd9,  5'd9,  5'd9,  32'h91, 32'h91, 32'h91, 32'h9, 32'h9, 32'h9,  1, 0));
    vq.push_back(mk(0, 1, 5'd0,  32'h1234,     0, 0, 5'd0,  5'd0,  5'd0,  32'h0,  32'h0,  32'h0,  32'h0, 32'h0, 32'h0,  1, 0));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        1, 0, 5'd0,  5'd9,  5'd0,  32'h0,  32'h91, 32'h0,  32'h0, 32'h91, 32'h0, 0, 1));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        1, 0, 5'd0,  5'd9,  5'd31, 32'h0,  32'h91, 32'h1F, 32'h0, 32'h91, 32'h1F, 0, 1));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        1, 0, 5'd0,  5'd9,  5'd31, 32'h0,  32'h91, 32'h1F, 32'h0, 32'h91, 32'h1F, 0, 1));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        0, 0, 5'd0,  5'd9,  5'd31, 32'h0,  32'h91, 32'h1F, 32'h0, 32'h91, 32'h1F, 0, 0));
    vq.push_back(mk(0, 1, 5'd10, 32'hAA,       0, 0, 5'd10, 5'd11, 5'd12, 32'hAA, 32'hB,  32'hC,  32'hA, 32'hB, 32'hC,  1, 0));
    vq.push_back(mk(0, 1, 5'd11, 32'hBB,       0, 0, 5'd10, 5'd11, 5'd12, 32'hAA, 32'hBB, 32'hC,  32'hA, 32'hB, 32'hC,  2, 0));
    vq.push_back(mk(0, 1, 5'd12, 32'hCC,       0, 0, 5'd10, 5'd11, 5'd12, 32'hAA, 32'hBB, 32'hCC, 32'hA, 32'hB, 32'hC,  3, 0));
    vq.push_back(mk(1, 1, 5'd13, 32'hDD,       1, 0, 5'd10, 5'd11, 5'd12, 32'hA,  32'hB,  32'hC,  32'hA, 32'hB, 32'hC,  0, 0));
    vq.push_back(mk(0, 0, 5'd0,  32'h0,        0, 0, 5'd5,  5'd13, 5'd4,  32'h5,  32'hD,  32'h4,  32'h5, 32'hD, 32'h4,  0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].we, vq[i].wa, vq[i].wd, vq[i].stp, vq[i].fl,
            vq[i].ra0, vq[i].ra1, vq[i].ra2);
      @(posedge clk);
      #1;
      chk("byp_rd0", i, port(rdB, 0), vq[i].b0);
      chk("byp_rd1", i, port(rdB, 1), vq[i].b1);
      chk("byp_rd2", i, port(rdB, 2), vq[i].b2);
      chk("nb_rd0",  i, port(rdN, 0), vq[i].n0);
      chk("nb_rd1",  i, port(rdN, 1), vq[i].n1);
      chk("nb_rd2",  i, port(rdN, 2), vq[i].n2);
      chk("byp_cnt", i, 32'(cntB), vq[i].cnt);
      chk("nb_cnt",  i, 32'(cntN), vq[i].cnt);
      chk("byp_done", i, 32'(doneB), 32'(vq[i].done));
      chk("nb_done",  i, 32'(doneN), 32'(vq[i].done));
    end

    // No same-cycle forwarding: the staged write is invisible until after the edge.
    drive(1'b0, 1'b1, 5'd20, 32'h5555, 1'b0, 1'b0, 5'd20, 5'd20, 5'd20);
    #1;
    chk("nofwd_pre", 100, port(rdB, 0), 32'h14);
    @(posedge clk);
    #1;
    chk("nofwd_byp", 101, port(rdB, 1), 32'h5555);
    chk("nofwd_nb",  101, port(rdN, 2), 32'h14);

    // Stage every entry including address 0: count saturates at 31 with r0 ignored.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b1, 5'(a), 32'h100 + 32'(a), 1'b0, 1'b0, 5'd0, 5'd20, 5'd31);
      @(posedge clk);
      #1;
    end
    chk("full_cnt_byp", 102, 32'(cntB), 32'd31);
    chk("full_cnt_nb",  102, 32'(cntN), 32'd31);
    chk("full_r0",      102, port(rdB, 0), 32'h0);
    chk("full_byp20",   102, port(rdB, 1), 32'h114);
    chk("full_nb31",    102, port(rdN, 2), 32'h1F);

    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd31, 5'd20, 5'd1);
    @(posedge clk);
    #1;
    chk("fullc_cnt",  103, 32'(cntN), 32'd0);
    chk("fullc_done", 103, 32'(doneN), 32'd1);
    chk("fullc_rd0",  103, port(rdN, 0), 32'h11F);
    chk("fullc_rd1",  103, port(rdN, 1), 32'h114);
    chk("fullc_rd2",  103, port(rdN, 2), 32'h101);

    // Reset landing in the pulse cycle clears the pulse at that edge.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd31, 5'd20, 5'd1);
    @(posedge clk);
    #1;
    chk("pulse_hi", 104, 32'(doneB), 32'd1);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd31, 5'd20, 5'd1);
    @(posedge clk);
    #1;
    chk("pulse_rst",  105, 32'(doneB), 32'd0);
    chk("rst_rd0",    105, port(rdB, 0), 32'h1F);
    chk("rst_rd1",    105, port(rdN, 1), 32'h14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
